instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory interface; owns the PC and drives the word address into the 256-entry instruction memory.
- The memory registers its output on posedge clk, so data returns one cycle after the address is sampled. This block tracks that in-flight fetch and tags the returned word with its PC and a valid bit.
- Handles branch redirect, decode stall, halt/resume and PC wrap-around. Feeds the IF/ID pipeline register.

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 41 ++++
 rtl/instr_fetch_unit_next_pc.sv | 44 ++++
 rtl/instr_fetch_unit.sv | 112 +++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch unit: FSM state encoding,
// memory geometry, reset PC and instruction width constants.
// No ports; imported by the interface, the next-PC mux and the fetch unit top.
package cpu_pkg;

  localparam int          INSTR_W    = 32;
  localparam int          IMEM_DEPTH = 256;
  localparam logic [31:0] RESET_PC   = 32'h0;

  // Encoding used by later stages when a bubble has to be injected.
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: pipeline control in, instruction-memory address/data, and
// the tagged fetch output towards the IF/ID register.
// master = fetch unit, slave = surrounding pipeline + memory.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  import cpu_pkg::*;

  logic               start;
  logic               halt;
  logic               stall;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] fetch_instr;
  logic [ADDR_W-1:0]  fetch_pc;
  logic               fetch_valid;
`ifdef IFU_PERF_CNT_EN
  logic [31:0]        perf_fetch_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  modport master (
    input  start, halt, stall, br_taken, br_target, imem_instr,
    output imem_addr, fetch_instr, fetch_pc, fetch_valid
`ifdef IFU_PERF_CNT_EN
    , output perf_fetch_cnt, perf_stall_cnt
`endif
  );

  modport slave (
    output start, halt, stall, br_taken, br_target, imem_instr,
    input  imem_addr, fetch_instr, fetch_pc, fetch_valid
`ifdef IFU_PERF_CNT_EN
    , input perf_fetch_cnt, perf_stall_cnt
`endif
  );

endinterface

// File: rtl/instr_fetch_unit_next_pc.sv
// Next-PC selection: priority mux (branch > stall > sequential) plus a
// modulo-IMEM_DEPTH incrementer. Purely combinational.
// Ports: state/pc/resume_pc/branch/stall in; seq_next_o and imem_addr_o out.
module ifu_next_pc #(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  cpu_pkg::ifu_state_t state_i,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [ADDR_W-1:0]   resume_pc_i,
  input  logic                br_taken_i,
  input  logic [ADDR_W-1:0]   br_target_i,
  input  logic                stall_i,
  output logic [ADDR_W-1:0]   seq_next_o,
  output logic [ADDR_W-1:0]   imem_addr_o
);
  import cpu_pkg::*;

  // IMEM_DEPTH is a power of two, so modulo is a mask of the low IDX_W bits.
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(IMEM_DEPTH - 1);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt_m;

  assign pc_inc = (pc_i + ADDR_W'(1)) & IDX_MASK;
  assign tgt_m  = br_target_i & IDX_MASK;

  assign seq_next_o = br_taken_i ? tgt_m :
                      stall_i    ? pc_i  : pc_inc;

  always_comb begin
    imem_addr_o = RESET_PC & IDX_MASK;
    case (state_i)
      IDLE:    imem_addr_o = RESET_PC & IDX_MASK;
      RUN:     imem_addr_o = seq_next_o;
      // A branch seen while halted is already presented to memory, so a
      // start in the same cycle fetches the target directly.
      HALTED:  imem_addr_o = br_taken_i ? tgt_m : resume_pc_i;
      default: imem_addr_o = RESET_PC & IDX_MASK;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the word address into a
// 1-cycle-latency instruction memory and tags the returned word with PC/valid.
// Ports: clk, rst (sync, active-high), bus (instr_fetch_unit_if.master).
// Optional macro IFU_PERF_CNT_EN adds fetch and stall performance counters.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_DEPTH = cpu_pkg::IMEM_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(cpu_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] IDX_MASK   = ADDR_W'(IMEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_M = RESET_PC & IDX_MASK;

  ifu_state_t        state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              valid_q;
  logic [ADDR_W-1:0] resume_pc_q;
  logic [ADDR_W-1:0] seq_next;
  logic [ADDR_W-1:0] next_addr;

  ifu_next_pc #(
    .ADDR_W     (ADDR_W),
    .IMEM_DEPTH (IMEM_DEPTH),
    .RESET_PC   (RESET_PC_M)
  ) u_next_pc (
    .state_i     (state_q),
    .pc_i        (pc_q),
    .resume_pc_i (resume_pc_q),
    .br_taken_i  (bus.br_taken),
    .br_target_i (bus.br_target),
    .stall_i     (bus.stall),
    .seq_next_o  (seq_next),
    .imem_addr_o (next_addr)
  );

  // pc_q always follows whatever the memory sampled at the edge the unit is
  // (or stays) in RUN, so the word returned next cycle matches fetch_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC_M;
      valid_q     <= 1'b0;
      resume_pc_q <= RESET_PC_M;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            pc_q    <= RESET_PC_M;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (bus.halt) begin
            // seq_next already folds in stall (re-fetch) and branch.
            state_q     <= HALTED;
            valid_q     <= 1'b0;
            resume_pc_q <= seq_next;
          end else begin
            pc_q    <= seq_next;
            valid_q <= 1'b1;
          end
        end
        HALTED: begin
          // next_addr is the masked target on a branch, else resume_pc_q.
          resume_pc_q <= next_addr;
          if (bus.start && !bus.halt) begin
            state_q <= RUN;
            pc_q    <= next_addr;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr   = next_addr;
  assign bus.fetch_instr = bus.imem_instr;
  assign bus.fetch_pc    = pc_q;
  assign bus.fetch_valid = valid_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;
  logic        run_active;

  assign run_active = (state_q == RUN) && !bus.halt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (run_active && (bus.br_taken || !bus.stall)) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (run_active && bus.stall)                    perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt = perf_fetch_q;
  assign bus.perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with literal expectations
// followed by randomized control traffic checked every cycle against a
// behavioural model of the fetch unit and a 1-cycle registered memory.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(32)) bus ();

  instr_fetch_unit #(
    .ADDR_W     (32),
    .IMEM_DEPTH (256),
    .RESET_PC   (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: registered read, one cycle latency.
  logic [31:0] mem [256];
  always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr[7:0]];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = idle, 1 = running, 2 = halted. Addresses are word indices 0..255.
  int          m_mode;
  int unsigned m_pc, m_res;
  bit          m_valid;
  bit          m_ok = 1'b0;
  int unsigned m_pf, m_ps;

  // Address the memory must be asked for this cycle given the model and inputs.
  function automatic int unsigned want_addr();
    int unsigned tgt;
    tgt = bus.br_target % 256;
    if (m_mode == 1) begin
      if (bus.br_taken)   return tgt;
      else if (bus.stall) return m_pc;
      else                return (m_pc + 1) % 256;
    end else if (m_mode == 2) begin
      return bus.br_taken ? tgt : m_res;
    end
    return 0;
  endfunction

  always @(posedge clk) begin
    int unsigned a;
    a = want_addr();
    if (rst) begin
      m_mode = 0; m_pc = 0; m_res = 0; m_valid = 0; m_pf = 0; m_ps = 0; m_ok = 1;
    end else if (m_mode == 0) begin
      if (bus.start) begin m_mode = 1; m_pc = 0; m_valid = 1; end
    end else if (m_mode == 1) begin
      if (!bus.halt) begin
        if (bus.br_taken || !bus.stall) m_pf++;
        if (bus.stall) m_ps++;
      end
      if (bus.halt) begin m_res = a; m_mode = 2; m_valid = 0; end
      else begin m_pc = a; m_valid = 1; end
    end else begin
      if (bus.br_taken) m_res = bus.br_target % 256;
      if (bus.start && !bus.halt) begin m_mode = 1; m_pc = m_res; m_valid = 1; end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_valid", {31'd0, bus.fetch_valid}, {31'd0, m_valid});
      chk("m_fetch_pc", bus.fetch_pc, m_pc);
      chk("m_imem_addr", bus.imem_addr, want_addr());
      if (m_valid) chk("m_fetch_instr", bus.fetch_instr, mem[m_pc[7:0]]);
`ifdef IFU_PERF_CNT_EN
      chk("m_perf_fetch", bus.perf_fetch_cnt, m_pf);
      chk("m_perf_stall", bus.perf_stall_cnt, m_ps);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1;
    bus.start = 0; bus.halt = 0; bus.stall = 0; bus.br_taken = 0; bus.br_target = '0;
    step(); step();
    rst = 1'b0;
    at_neg();
    chk("rst_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_pc", bus.fetch_pc, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'd0);

    // Start: valid one cycle later at PC 0.
    bus.start = 1; step(); bus.start = 0;
    at_neg();
    chk("start_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("start_pc", bus.fetch_pc, 32'd0);
    chk("start_instr", bus.fetch_instr, mem[0]);

    repeat (7) step();
    at_neg();
    chk("seq_pc7", bus.fetch_pc, 32'd7);

    // Three stalled cycles hold PC 7.
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("stall_pc", bus.fetch_pc, 32'd7);
      chk("stall_instr", bus.fetch_instr, mem[7]);
      chk("stall_valid", {31'd0, bus.fetch_valid}, 32'd1);
      chk("stall_addr", bus.imem_addr, 32'd7);
      step();
    end
    bus.stall = 0;
    step();
    at_neg();
    chk("after_stall_pc", bus.fetch_pc, 32'd8);

    // Branch beats stall.
    repeat (8) step();
    at_neg();
    chk("pc16", bus.fetch_pc, 32'd16);
    bus.br_taken = 1; bus.br_target = 32'd5; bus.stall = 1;
    step();
    bus.br_taken = 0; bus.stall = 0;
    at_neg();
    chk("br_pc", bus.fetch_pc, 32'd5);
    chk("br_valid", {31'd0, bus.fetch_valid}, 32'd1);
    step();
    at_neg();
    chk("br_next_pc", bus.fetch_pc, 32'd6);

    // Wrap-around and target masking.
    bus.br_taken = 1; bus.br_target = 32'd255; step(); bus.br_taken = 0;
    at_neg();
    chk("pc255", bus.fetch_pc, 32'd255);
    step();
    at_neg();
    chk("wrap_pc", bus.fetch_pc, 32'd0);
    bus.br_taken = 1; bus.br_target = 32'h105; step(); bus.br_taken = 0;
    at_neg();
    chk("mask_pc", bus.fetch_pc, 32'd5);
    chk("mask_instr", bus.fetch_instr, mem[5]);

    // Halt, branch while halted, resume at the branch target.
    repeat (5) step();
    bus.halt = 1; step(); bus.halt = 0;
    at_neg();
    chk("halt_valid", {31'd0, bus.fetch_valid}, 32'd0);
    bus.br_taken = 1; bus.br_target = 32'd20; step(); bus.br_taken = 0;
    bus.start = 1;
    at_neg();
    chk("resume_addr", bus.imem_addr, 32'd20);
    step(); bus.start = 0;
    at_neg();
    chk("resume_pc", bus.fetch_pc, 32'd20);
    chk("resume_valid", {31'd0, bus.fetch_valid}, 32'd1);
    chk("resume_instr", bus.fetch_instr, mem[20]);

    // Reset mid-run.
    bus.br_taken = 1; bus.br_target = 32'd12; step(); bus.br_taken = 0;
    at_neg();
    chk("pc12", bus.fetch_pc, 32'd12);
    rst = 1; step(); rst = 0;
    at_neg();
    chk("midrst_valid", {31'd0, bus.fetch_valid}, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'd0);
    chk("midrst_pc", bus.fetch_pc, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("midrst_pf", bus.perf_fetch_cnt, 32'd0);
    chk("midrst_ps", bus.perf_stall_cnt, 32'd0);
`endif

    // Randomized control traffic.
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.start    = ($urandom_range(0, 7) == 0);
      bus.halt     = ($urandom_range(0, 19) == 0);
      bus.stall    = ($urandom_range(0, 3) == 0);
      bus.br_taken = ($urandom_range(0, 7) == 0);
      bus.br_target = $urandom;
      step();
    end
    rst = 0; bus.start = 0; bus.halt = 0; bus.stall = 0; bus.br_taken = 0;
    step();
    at_neg();
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
